// File: rtl/percept_exec.sv
// Perceptron execution datapath: serial load/unload of the two operands and the
// accumulator, plus one-cycle multiply and multiply-accumulate.
module percept_exec #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic [2:0]       opcode,
   input  logic             op_start,
   input  logic             rx,
   output logic             tx,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] res
);

   localparam int CNT_W = $clog2(ACC_W + 1);

   typedef enum logic [2:0] {
      OP_OUT_DATA1 = 3'd0,
      OP_OUT_DATA2 = 3'd1,
      OP_OUT_RES   = 3'd2,
      OP_LOAD      = 3'd3,
      OP_LOAD_RES  = 3'd4,
      OP_MUL       = 3'd5,
      OP_MUL_ADD   = 3'd6,
      OP_NO_OP     = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_IN,
      S_SHIFT_OUT,
      S_COMPUTE,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] data1_q, data1_d;
   logic [WIDTH-1:0] data2_q, data2_d;
   logic [ACC_W-1:0] res_q, res_d;
   logic             tx_q, tx_d;
   logic [ACC_W-1:0] prod;
   logic [ACC_W-1:0] out_src;

   // One shift register serves both directions: rx enters at the LSB, tx leaves from the MSB.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch can be inferred.
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      data1_d = data1_q;
      data2_d = data2_q;
      res_d   = res_q;
      tx_d    = 1'b1;
      out_src = '0;
      prod    = ACC_W'(data1_q) * ACC_W'(data2_q);

      case (state_q)
         S_IDLE: begin
            if (op_start) begin
               op_d = op_e'(opcode);
               case (op_e'(opcode))
                  OP_LOAD: begin
                     cnt_d   = CNT_W'(2 * WIDTH);
                     state_d = S_SHIFT_IN;
                  end
                  OP_LOAD_RES: begin
                     cnt_d   = CNT_W'(ACC_W);
                     state_d = S_SHIFT_IN;
                  end
                  OP_OUT_DATA1: begin
                     out_src = {data1_q, {(ACC_W - WIDTH){1'b0}}};
                     cnt_d   = CNT_W'(WIDTH);
                     state_d = S_SHIFT_OUT;
                  end
                  OP_OUT_DATA2: begin
                     out_src = {data2_q, {(ACC_W - WIDTH){1'b0}}};
                     cnt_d   = CNT_W'(WIDTH);
                     state_d = S_SHIFT_OUT;
                  end
                  OP_OUT_RES: begin
                     out_src = res_q;
                     cnt_d   = CNT_W'(ACC_W);
                     state_d = S_SHIFT_OUT;
                  end
                  OP_MUL, OP_MUL_ADD: state_d = S_COMPUTE;
                  default:            state_d = S_DONE;
               endcase
               // The MSB goes out right away so the stream starts the cycle after acceptance.
               if (state_d == S_SHIFT_OUT) begin
                  tx_d = out_src[ACC_W-1];
                  sr_d = out_src << 1;
               end
            end
         end

         S_SHIFT_IN: begin
            sr_d  = {sr_q[ACC_W-2:0], rx};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
               if (op_q == OP_LOAD) begin
                  data1_d = sr_d[2*WIDTH-1:WIDTH];
                  data2_d = sr_d[WIDTH-1:0];
               end else begin
                  res_d = sr_d;
               end
            end
         end

         S_SHIFT_OUT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end else begin
               tx_d = sr_q[ACC_W-1];
               sr_d = sr_q << 1;
            end
         end

         S_COMPUTE: begin
            res_d   = (op_q == OP_MUL_ADD) ? res_q + prod : prod;
            state_d = S_DONE;
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= S_IDLE;
         op_q    <= OP_NO_OP;
         cnt_q   <= '0;
         sr_q    <= '0;
         data1_q <= '0;
         data2_q <= '0;
         res_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         res_q   <= res_d;
         tx_q    <= tx_d;
      end
   end

   assign tx   = tx_q;
   assign res  = res_q;
   assign done = (state_q == S_DONE);
   assign busy = (state_q == S_SHIFT_IN) || (state_q == S_SHIFT_OUT) || (state_q == S_COMPUTE);

endmodule

// File: tb/tb_percept_exec.sv
// Scoreboard bench for percept_exec: the driver queues the expected outcome of each
// operation, the monitor checks result, latency, busy span and tx stream at done.
module tb_percept_exec;

   localparam int WIDTH = 8;
   localparam int ACC_W = 16;

   logic             clk = 1'b0;
   logic             nRst = 1'b0;
   logic [2:0]       opcode = 3'd0;
   logic             op_start = 1'b0;
   logic             rx = 1'b0;
   logic             tx;
   logic             busy;
   logic             done;
   logic [ACC_W-1:0] res;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [ACC_W-1:0] res;
      logic [ACC_W-1:0] stream;
      int               n_tx;
      int               lat;
      int               bsy;
      int               start;
   } exp_t;

   exp_t sb[$];

   percept_exec #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
      .clk      (clk),
      .nRst     (nRst),
      .opcode   (opcode),
      .op_start (op_start),
      .rx       (rx),
      .tx       (tx),
      .busy     (busy),
      .done     (done),
      .res      (res)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Monitor: collects tx while busy and scores each done pulse against the queue head.
   int               busy_cnt = 0;
   logic [ACC_W-1:0] tx_log = '0;

   always @(negedge clk) begin
      if (!nRst) begin
         busy_cnt = 0;
         tx_log   = '0;
      end else if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no pending operation (t=%0t)", $time);
         end else begin
            exp_t        e;
            logic [31:0] m;
            e = sb.pop_front();
            m = (e.n_tx >= 32) ? 32'hFFFF_FFFF : (32'd1 << e.n_tx) - 32'd1;
            check("res_at_done", 32'(res), 32'(e.res));
            check("latency", 32'(cyc - e.start), 32'(e.lat));
            check("busy_cycles", 32'(busy_cnt), 32'(e.bsy));
            check("tx_idle_at_done", 32'(tx), 32'd1);
            if (e.n_tx > 0) check("tx_stream", 32'(tx_log) & m, 32'(e.stream));
         end
         busy_cnt = 0;
         tx_log   = '0;
      end else if (busy) begin
         busy_cnt++;
         tx_log = {tx_log[ACC_W-2:0], tx};
      end
   end

   // Issues one operation; glitch_at injects a stray LOAD request and opcode noise,
   // abort_at pulls reset at that bit and drops the queued expectation.
   task automatic run_op(input logic [2:0] op, input logic [31:0] word, input int n_rx,
                         input logic [ACC_W-1:0] e_res, input logic [ACC_W-1:0] e_stream,
                         input int n_tx, input int lat, input int bsy,
                         input int glitch_at, input int abort_at);
      exp_t e;
      bit   got = 1'b0;
      bit   aborted = 1'b0;
      e.res    = e_res;
      e.stream = e_stream;
      e.n_tx   = n_tx;
      e.lat    = lat;
      e.bsy    = bsy;
      e.start  = cyc;
      sb.push_back(e);
      opcode   = op;
      op_start = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         op_start = 1'b0;
         if (glitch_at > 0) opcode = 3'($urandom);
         if (k == glitch_at) begin
            op_start = 1'b1;
            opcode   = 3'd3;
         end
         rx = (k <= n_rx) ? word[n_rx-k] : 1'($urandom);
         if (k == abort_at) begin
            nRst = 1'b0;
            sb.delete(sb.size() - 1);
            #1;
            check("abort_res", 32'(res), 32'd0);
            check("abort_tx", 32'(tx), 32'd1);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            @(negedge clk);
            #2 nRst = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got && !aborted) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done for opcode %0d, expected done within 60 cycles", op);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nRst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_res", 32'(res), 32'd0);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      #2 nRst = 1'b1;
      @(negedge clk);

      //     op    rx word       n_rx res       stream    n_tx lat bsy glitch abort
      run_op(3'd3, 32'h0000A53C, 16, 16'h0000, 16'h0000, 0,  17, 16, 0, 0);  // LOAD A5/3C
      run_op(3'd0, 32'h0,        0,  16'h0000, 16'h00A5, 8,  9,  8,  0, 0);  // OUT_DATA1
      run_op(3'd1, 32'h0,        0,  16'h0000, 16'h003C, 8,  9,  8,  0, 0);  // OUT_DATA2
      run_op(3'd5, 32'h0,        0,  16'h26AC, 16'h0000, 0,  2,  1,  0, 0);  // MUL
      run_op(3'd6, 32'h0,        0,  16'h4D58, 16'h0000, 0,  2,  1,  0, 0);  // MUL_ADD
      run_op(3'd4, 32'h0000FFFF, 16, 16'hFFFF, 16'h0000, 0,  17, 16, 0, 0);  // LOAD_RES
      run_op(3'd6, 32'h0,        0,  16'h26AB, 16'h0000, 0,  2,  1,  0, 0);  // MUL_ADD wraps
      run_op(3'd2, 32'h0,        0,  16'h26AB, 16'h26AB, 16, 17, 16, 0, 0);  // OUT_RES
      run_op(3'd3, 32'h00005AC3, 16, 16'h26AB, 16'h0000, 0,  17, 16, 4, 0);  // LOAD, stray start
      run_op(3'd0, 32'h0,        0,  16'h26AB, 16'h005A, 8,  9,  8,  0, 0);
      run_op(3'd1, 32'h0,        0,  16'h26AB, 16'h00C3, 8,  9,  8,  0, 0);
      run_op(3'd5, 32'h0,        0,  16'h448E, 16'h0000, 0,  2,  1,  0, 0);  // 0x5A*0xC3
      run_op(3'd3, 32'h0000A53C, 16, 16'h0000, 16'h0000, 0,  17, 16, 0, 5);  // reset at bit 5
      repeat (3) @(negedge clk);
      run_op(3'd7, 32'h0,        0,  16'h0000, 16'h0000, 0,  1,  0,  0, 0);  // NO_OP
      run_op(3'd0, 32'h0,        0,  16'h0000, 16'h0000, 8,  9,  8,  0, 0);  // data1 cleared
      run_op(3'd1, 32'h0,        0,  16'h0000, 16'h0000, 8,  9,  8,  0, 0);  // data2 cleared
      run_op(3'd2, 32'h0,        0,  16'h0000, 16'h0000, 16, 17, 16, 0, 0);  // res cleared

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
